// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB-to-I2C CSR block: register offsets,
// access FSM states and interrupt bit positions.
package apb_i2c_pkg;

    // Byte offsets of the decoded registers (low 5 address bits)
    localparam logic [4:0] TXDATA_OFF   = 5'h00;
    localparam logic [4:0] RXDATA_OFF   = 5'h04;
    localparam logic [4:0] CONFIG_OFF   = 5'h08;
    localparam logic [4:0] TIMEOUT_OFF  = 5'h0C;
    localparam logic [4:0] STATUS_OFF   = 5'h10;
    localparam logic [4:0] INT_EN_OFF   = 5'h14;
    localparam logic [4:0] INT_STAT_OFF = 5'h18;

    // Access FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TX_STALL = 2'd1,
        RX_WAIT  = 2'd2,
        RX_DONE  = 2'd3
    } state_t;

    // Interrupt bit positions and width
    localparam int INT_TXE  = 0;
    localparam int INT_RXNE = 1;
    localparam int INT_ERR  = 2;
    localparam int INT_W    = 3;

endpackage

// File: rtl/apb_i2c_irq.sv
// Interrupt block: edge detection on FIFO/error flags, INT_EN and
// write-1-to-clear INT_STAT registers, and a registered IRQ output.
module apb_i2c_irq
    import apb_i2c_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_empty,
    input  logic             rx_empty,
    input  logic             error,
    input  logic             en_we,
    input  logic             stat_we,
    input  logic [INT_W-1:0] wdata,
    output logic [INT_W-1:0] int_en,
    output logic [INT_W-1:0] int_stat,
    output logic             irq
);

    logic             tx_empty_prev;
    logic             rx_empty_prev;
    logic             error_prev;
    logic [INT_W-1:0] set_ev;
    logic [INT_W-1:0] clr_ev;
    logic [INT_W-1:0] int_stat_next;

    // Event detection: TX FIFO drained, RX FIFO got data, core error raised
    always_comb begin
        set_ev           = '0;
        set_ev[INT_TXE]  = tx_empty & ~tx_empty_prev;
        set_ev[INT_RXNE] = ~rx_empty & rx_empty_prev;
        set_ev[INT_ERR]  = error & ~error_prev;
    end

    assign clr_ev = stat_we ? wdata : '0;

    // Per-bit update; a new event in the same cycle as a clear keeps the bit set
    generate
        for (genvar gi = 0; gi < INT_W; gi++) begin : g_stat
            assign int_stat_next[gi] = set_ev[gi] | (int_stat[gi] & ~clr_ev[gi]);
        end
    endgenerate

    // Flag history, interrupt registers and IRQ, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_empty_prev <= 1'b1;
            rx_empty_prev <= 1'b1;
            error_prev    <= 1'b0;
            int_en        <= '0;
            int_stat      <= '0;
            irq           <= 1'b0;
        end else begin
            tx_empty_prev <= tx_empty;
            rx_empty_prev <= rx_empty;
            error_prev    <= error;
            if (en_we) begin
                int_en <= wdata;
            end
            int_stat <= int_stat_next;
            irq      <= |(int_stat & int_en);
        end
    end

endmodule

// File: rtl/apb_i2c_csr.sv
// APB slave front-end for the I2C core: TX/RX FIFO access with wait
// states, CONFIG/TIMEOUT/STATUS registers, error decode and interrupts.
module apb_i2c_csr
    import apb_i2c_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int CFG_W     = 14,
    parameter int TMO_W     = 14,
    parameter int RD_LAT    = 1,
    parameter int STALL_MAX = 15
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              WR_ENA,
    output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
    input  logic              TX_FULL,
    input  logic              TX_EMPTY,
    output logic              RD_ENA,
    input  logic [DATA_W-1:0] READ_DATA_ON_RX,
    input  logic              RX_EMPTY,
    input  logic              ERROR,
    output logic [CFG_W-1:0]  INTERNAL_I2C_REGISTER_CONFIG,
    output logic [TMO_W-1:0]  INTERNAL_I2C_REGISTER_TIMEOUT,
    output logic              IRQ
);

    localparam int               SC_W      = $clog2(STALL_MAX + 1);
    localparam logic [SC_W-1:0]  STALL_LIM = SC_W'(STALL_MAX);
    localparam logic [2:0]       LAT_INIT  = 3'(RD_LAT);

    state_t            state;
    state_t            state_next;
    logic [SC_W-1:0]   stall_cnt;
    logic [2:0]        lat_cnt;
    logic [DATA_W-1:0] rx_q;
    logic [CFG_W-1:0]  cfg_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic [INT_W-1:0]  int_en;
    logic [INT_W-1:0]  int_stat;
    logic [DATA_W-1:0] csr_rdata;

    logic [4:0] off;
    logic       upper_ok;
    logic       hit_tx, hit_rx, hit_cfg, hit_tmo, hit_sts, hit_en, hit_ist;
    logic       is_csr, legal, access, idle_acc, csr_we;

    // Address decode; only aligned offsets match, so misalignment falls out as unmapped
    assign off      = PADDR[4:0];
    assign upper_ok = (PADDR[ADDR_W-1:5] == '0);
    assign hit_tx   = upper_ok && (off == TXDATA_OFF);
    assign hit_rx   = upper_ok && (off == RXDATA_OFF);
    assign hit_cfg  = upper_ok && (off == CONFIG_OFF);
    assign hit_tmo  = upper_ok && (off == TIMEOUT_OFF);
    assign hit_sts  = upper_ok && (off == STATUS_OFF);
    assign hit_en   = upper_ok && (off == INT_EN_OFF);
    assign hit_ist  = upper_ok && (off == INT_STAT_OFF);
    assign is_csr   = hit_cfg | hit_tmo | hit_sts | hit_en | hit_ist;
    assign legal    = PWRITE ? (hit_tx | hit_cfg | hit_tmo | hit_en | hit_ist)
                             : (hit_rx | hit_cfg | hit_tmo | hit_sts | hit_en | hit_ist);
    assign access   = PRESETn & PSELx & PENABLE;
    assign idle_acc = access && (state == IDLE);
    assign csr_we   = idle_acc && legal && PWRITE && is_csr;

    assign WRITE_DATA_ON_TX              = PWDATA;
    assign INTERNAL_I2C_REGISTER_CONFIG  = cfg_reg;
    assign INTERNAL_I2C_REGISTER_TIMEOUT = tmo_reg;

    // Zero-extended CSR read mux
    always_comb begin
        csr_rdata = '0;
        case (off)
            CONFIG_OFF:   csr_rdata = DATA_W'(cfg_reg);
            TIMEOUT_OFF:  csr_rdata = DATA_W'(tmo_reg);
            STATUS_OFF:   csr_rdata = DATA_W'({ERROR, RX_EMPTY, TX_FULL, TX_EMPTY});
            INT_EN_OFF:   csr_rdata = DATA_W'(int_en);
            INT_STAT_OFF: csr_rdata = DATA_W'(int_stat);
            default:      csr_rdata = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; dropping PSELx mid-transfer aborts back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (idle_acc && legal && hit_tx && TX_FULL) begin
                    state_next = TX_STALL;
                end else if (idle_acc && legal && hit_rx && !RX_EMPTY) begin
                    state_next = RX_WAIT;
                end
            end
            TX_STALL: begin
                if (!PSELx || !TX_FULL || (stall_cnt >= STALL_LIM)) begin
                    state_next = IDLE;
                end
            end
            RX_WAIT: begin
                if (!PSELx) begin
                    state_next = IDLE;
                end else if (lat_cnt == 3'd1) begin
                    state_next = RX_DONE;
                end
            end
            RX_DONE:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM outputs: APB handshake and FIFO strobes, all forced low in reset
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        WR_ENA  = 1'b0;
        RD_ENA  = 1'b0;
        PRDATA  = '0;
        if (PRESETn) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (!legal) begin
                            PREADY  = 1'b1;
                            PSLVERR = 1'b1;
                        end else if (hit_tx) begin
                            if (!TX_FULL) begin
                                WR_ENA = 1'b1;
                                PREADY = 1'b1;
                            end
                        end else if (hit_rx) begin
                            if (RX_EMPTY) begin
                                PREADY  = 1'b1;
                                PSLVERR = 1'b1;
                            end else begin
                                RD_ENA = 1'b1;
                            end
                        end else begin
                            PREADY = 1'b1;
                            if (!PWRITE) begin
                                PRDATA = csr_rdata;
                            end
                        end
                    end
                end
                TX_STALL: begin
                    if (PSELx) begin
                        if (!TX_FULL) begin
                            WR_ENA = 1'b1;
                            PREADY = 1'b1;
                        end else if (stall_cnt >= STALL_LIM) begin
                            PREADY  = 1'b1;
                            PSLVERR = 1'b1;
                        end
                    end
                end
                RX_DONE: begin
                    if (PSELx) begin
                        PREADY = 1'b1;
                        PRDATA = rx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall/latency counters and RX data capture
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            stall_cnt <= '0;
            lat_cnt   <= '0;
            rx_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= (state_next == TX_STALL) ? SC_W'(1) : '0;
                    lat_cnt   <= (state_next == RX_WAIT) ? LAT_INIT : 3'd0;
                end
                TX_STALL: begin
                    stall_cnt <= (state_next == TX_STALL) ? stall_cnt + 1'b1 : '0;
                end
                RX_WAIT: begin
                    lat_cnt <= (state_next == RX_WAIT) ? lat_cnt - 3'd1 : 3'd0;
                    if (PSELx && (lat_cnt == 3'd1)) begin
                        rx_q <= READ_DATA_ON_RX;
                    end
                end
                default: begin
                    stall_cnt <= '0;
                    lat_cnt   <= '0;
                end
            endcase
        end
    end

    // CONFIG and TIMEOUT registers, zero-wait writes
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cfg_reg <= '0;
            tmo_reg <= '0;
        end else begin
            if (csr_we && hit_cfg) begin
                cfg_reg <= PWDATA[CFG_W-1:0];
            end
            if (csr_we && hit_tmo) begin
                tmo_reg <= PWDATA[TMO_W-1:0];
            end
        end
    end

    apb_i2c_irq u_irq (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .tx_empty (TX_EMPTY),
        .rx_empty (RX_EMPTY),
        .error    (ERROR),
        .en_we    (csr_we && hit_en),
        .stat_we  (csr_we && hit_ist),
        .wdata    (PWDATA[INT_W-1:0]),
        .int_en   (int_en),
        .int_stat (int_stat),
        .irq      (IRQ)
    );

endmodule

// File: tb/tb_apb_i2c_csr.sv
// Directed scoreboard bench for apb_i2c_csr (RD_LAT=3, STALL_MAX=15).
module tb_apb_i2c_csr;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int CFG_W     = 14;
    localparam int TMO_W     = 14;
    localparam int RD_LAT    = 3;
    localparam int STALL_MAX = 15;

    logic              PCLK = 1'b0;
    logic              PRESETn, PSELx, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic              PREADY, PSLVERR, WR_ENA, RD_ENA;
    logic [DATA_W-1:0] WRITE_DATA_ON_TX, READ_DATA_ON_RX;
    logic              TX_FULL, TX_EMPTY, RX_EMPTY, ERROR, IRQ;
    logic [CFG_W-1:0]  INTERNAL_I2C_REGISTER_CONFIG;
    logic [TMO_W-1:0]  INTERNAL_I2C_REGISTER_TIMEOUT;

    always #5 PCLK = ~PCLK;

    apb_i2c_csr #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_W(CFG_W), .TMO_W(TMO_W),
        .RD_LAT(RD_LAT), .STALL_MAX(STALL_MAX)
    ) dut (
        .PCLK                          (PCLK),
        .PRESETn                       (PRESETn),
        .PSELx                         (PSELx),
        .PENABLE                       (PENABLE),
        .PWRITE                        (PWRITE),
        .PADDR                         (PADDR),
        .PWDATA                        (PWDATA),
        .PRDATA                        (PRDATA),
        .PREADY                        (PREADY),
        .PSLVERR                       (PSLVERR),
        .WR_ENA                        (WR_ENA),
        .WRITE_DATA_ON_TX              (WRITE_DATA_ON_TX),
        .TX_FULL                       (TX_FULL),
        .TX_EMPTY                      (TX_EMPTY),
        .RD_ENA                        (RD_ENA),
        .READ_DATA_ON_RX               (READ_DATA_ON_RX),
        .RX_EMPTY                      (RX_EMPTY),
        .ERROR                         (ERROR),
        .INTERNAL_I2C_REGISTER_CONFIG  (INTERNAL_I2C_REGISTER_CONFIG),
        .INTERNAL_I2C_REGISTER_TIMEOUT (INTERNAL_I2C_REGISTER_TIMEOUT),
        .IRQ                           (IRQ)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
        int          wrs;
        int          rds;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] rdata, input logic err,
                           input int cycles, input int wrs, input int rds);
        exp_t e;
        e.tag = tag; e.rdata = rdata; e.err = err;
        e.cycles = cycles; e.wrs = wrs; e.rds = rds;
        sb.push_back(e);
    endtask

    // One APB transfer; observed result is compared against the oldest scoreboard entry
    task automatic apb(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t        e;
        int          cycles = 0;
        int          wrs    = 0;
        int          rds    = 0;
        logic [31:0] rdata  = '0;
        logic        err    = 1'b0;
        bit          done   = 1'b0;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        while (!done && cycles < 40) begin
            @(negedge PCLK);
            cycles++;
            wrs += int'(WR_ENA);
            rds += int'(RD_ENA);
            if (WR_ENA) chk("tx_data", WRITE_DATA_ON_TX, d);
            if (PREADY) begin
                done  = 1'b1;
                rdata = PRDATA;
                err   = PSLVERR;
            end
            @(posedge PCLK); #1;
        end
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_cycles"}, 32'(cycles), 32'(e.cycles));
            chk({e.tag, "_err"},    32'(err),    32'(e.err));
            chk({e.tag, "_rdata"},  rdata,       e.rdata);
            chk({e.tag, "_wr_ena"}, 32'(wrs),    32'(e.wrs));
            chk({e.tag, "_rd_ena"}, 32'(rds),    32'(e.rds));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0; PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
        PADDR = 12'h008; PWDATA = '0;
        TX_FULL = 1'b0; TX_EMPTY = 1'b1; RX_EMPTY = 1'b1; ERROR = 1'b0;
        READ_DATA_ON_RX = 32'hDEAD_BEEF;

        // Outputs held low during reset even with an access presented
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready",  32'(PREADY),  0);
        chk("rst_pslverr", 32'(PSLVERR), 0);
        chk("rst_irq",     32'(IRQ),     0);
        chk("rst_cfg",     32'(INTERNAL_I2C_REGISTER_CONFIG), 0);
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;

        // Reset values of RW registers
        sb_push("rd_cfg0",  0, 1'b0, 1, 0, 0); apb(1'b0, 12'h008, '0);
        sb_push("rd_tmo0",  0, 1'b0, 1, 0, 0); apb(1'b0, 12'h00C, '0);
        sb_push("rd_ien0",  0, 1'b0, 1, 0, 0); apb(1'b0, 12'h014, '0);
        sb_push("rd_ist0",  0, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);

        // CONFIG / TIMEOUT write and read-back
        sb_push("wr_cfg", 0, 1'b0, 1, 0, 0); apb(1'b1, 12'h008, 32'hDEAD_3FFF);
        chk("cfg_out", 32'(INTERNAL_I2C_REGISTER_CONFIG), 32'h3FFF);
        sb_push("rd_cfg", 32'h3FFF, 1'b0, 1, 0, 0); apb(1'b0, 12'h008, '0);
        sb_push("wr_tmo", 0, 1'b0, 1, 0, 0); apb(1'b1, 12'h00C, 32'h0000_1234);
        chk("tmo_out", 32'(INTERNAL_I2C_REGISTER_TIMEOUT), 32'h1234);
        sb_push("rd_tmo", 32'h1234, 1'b0, 1, 0, 0); apb(1'b0, 12'h00C, '0);

        // TX push without stall
        sb_push("tx_push", 0, 1'b0, 1, 1, 0); apb(1'b1, 12'h000, 32'h0000_0011);

        // TX full for 3 access cycles, then released
        TX_FULL = 1'b1;
        sb_push("tx_stall3", 0, 1'b0, 4, 1, 0);
        fork
            apb(1'b1, 12'h000, 32'h0000_0022);
            begin repeat (5) @(posedge PCLK); #1; TX_FULL = 1'b0; end
        join

        // TX full throughout: error after STALL_MAX stall cycles, no push
        TX_FULL = 1'b1;
        sb_push("tx_tmo", 0, 1'b1, STALL_MAX + 1, 0, 0); apb(1'b1, 12'h000, 32'h0000_0033);
        TX_FULL = 1'b0;

        // Illegal accesses complete at once with error and no side effects
        sb_push("ill_wr_sts",  0, 1'b1, 1, 0, 0); apb(1'b1, 12'h010, 32'hFFFF_FFFF);
        sb_push("ill_rd_tx",   0, 1'b1, 1, 0, 0); apb(1'b0, 12'h000, '0);
        sb_push("ill_wr_1c",   0, 1'b1, 1, 0, 0); apb(1'b1, 12'h01C, 32'h7);
        sb_push("ill_rd_09",   0, 1'b1, 1, 0, 0); apb(1'b0, 12'h009, '0);
        sb_push("ill_wr_0a",   0, 1'b1, 1, 0, 0); apb(1'b1, 12'h00A, '0);
        sb_push("ill_wr_rx",   0, 1'b1, 1, 0, 0); apb(1'b1, 12'h004, 32'h5);
        sb_push("ill_wr_upr",  0, 1'b1, 1, 0, 0); apb(1'b1, 12'h108, '0);
        sb_push("ill_wr_ist",  0, 1'b1, 1, 0, 0); apb(1'b1, 12'h118, '0);
        chk("ill_cfg_kept", 32'(INTERNAL_I2C_REGISTER_CONFIG), 32'h3FFF);
        sb_push("ill_ien_kept", 0, 1'b0, 1, 0, 0); apb(1'b0, 12'h014, '0);

        // Interrupt enable and ERROR rising edge
        sb_push("wr_ien", 0, 1'b0, 1, 0, 0); apb(1'b1, 12'h014, 32'h7);
        sb_push("rd_ien", 32'h7, 1'b0, 1, 0, 0); apb(1'b0, 12'h014, '0);
        ERROR = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK); chk("irq_lag", 32'(IRQ), 0);
        @(posedge PCLK);
        @(negedge PCLK); chk("irq_set", 32'(IRQ), 1);
        ERROR = 1'b0;
        sb_push("ist_err", 32'h4, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);
        sb_push("w1c_err", 0, 1'b0, 1, 0, 0); apb(1'b1, 12'h018, 32'h4);
        sb_push("ist_clr", 0, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);
        chk("irq_clr", 32'(IRQ), 0);

        // W1C coinciding with a new ERROR edge: set wins
        ERROR = 1'b1; tick(2); ERROR = 1'b0; tick(1);
        sb_push("w1c_vs_set", 0, 1'b0, 1, 0, 0);
        fork
            apb(1'b1, 12'h018, 32'h4);
            begin repeat (2) @(posedge PCLK); #1; ERROR = 1'b1; end
        join
        sb_push("ist_setwin", 32'h4, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);
        ERROR = 1'b0;
        sb_push("w1c_err2", 0, 1'b0, 1, 0, 0); apb(1'b1, 12'h018, 32'h4);
        sb_push("ist_clr2", 0, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);

        // TX_EMPTY rising edge sets bit 0
        TX_EMPTY = 1'b0; tick(2); TX_EMPTY = 1'b1; tick(2);
        sb_push("ist_txe", 32'h1, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);

        // RX read with latency; data only valid from cycle RD_LAT after the pop
        RX_EMPTY = 1'b0;
        READ_DATA_ON_RX = 32'hDEAD_BEEF;
        sb_push("rx_read", 32'hA5A5_A5A5, 1'b0, RD_LAT + 2, 0, 1);
        fork
            apb(1'b0, 12'h004, '0);
            begin repeat (5) @(posedge PCLK); #1; READ_DATA_ON_RX = 32'hA5A5_A5A5; end
        join
        sb_push("ist_rxne", 32'h3, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);
        chk("irq_rxne", 32'(IRQ), 1);

        // RX read while empty
        RX_EMPTY = 1'b1;
        READ_DATA_ON_RX = 32'h1357_9BDF;
        sb_push("rx_empty", 0, 1'b1, 1, 0, 0); apb(1'b0, 12'h004, '0);

        // STATUS reflects live flags
        sb_push("rd_sts5", 32'h5, 1'b0, 1, 0, 0); apb(1'b0, 12'h010, '0);
        TX_FULL = 1'b1;
        sb_push("rd_sts7", 32'h7, 1'b0, 1, 0, 0); apb(1'b0, 12'h010, '0);

        // Reset in the middle of a stalled TX write
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h44;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        tick(3);
        PRESETn = 1'b0; TX_FULL = 1'b0;
        @(negedge PCLK);
        chk("mid_rst_wr_ena", 32'(WR_ENA), 0);
        chk("mid_rst_pready", 32'(PREADY), 0);
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESETn = 1'b1;
        chk("mid_rst_cfg", 32'(INTERNAL_I2C_REGISTER_CONFIG), 0);
        chk("mid_rst_tmo", 32'(INTERNAL_I2C_REGISTER_TIMEOUT), 0);
        @(negedge PCLK); chk("mid_rst_irq", 32'(IRQ), 0);
        sb_push("post_rst_ist", 0, 1'b0, 1, 0, 0); apb(1'b0, 12'h018, '0);
        sb_push("post_rst_tx",  0, 1'b0, 1, 1, 0); apb(1'b1, 12'h000, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_i2c_csr.md
Name: apb_i2c_csr

Overview:
Parametrised APB slave that sits between the APB bus and the I2C core's TX/RX FIFOs and configuration inputs. It adds wait-state handling for FIFO full/empty and RX read latency, and decodes illegal accesses to PSLVERR. It also provides a status register and a maskable, write-1-to-clear interrupt block with a single IRQ output.

Parameters:
ADDR_W, 12, PADDR width; only the low 5 bits are decoded, upper bits must be zero.
DATA_W, 32, PWDATA/PRDATA/FIFO data width (>= 16).
CFG_W, 14, CONFIG register width (<= DATA_W).
TMO_W, 14, TIMEOUT register width (<= DATA_W).
RD_LAT, 1, cycles from RD_ENA to valid READ_DATA_ON_RX (1..7).
STALL_MAX, 15, maximum TX-full wait cycles before the access errors (>= 1).

Ports:
PCLK  in  1  APB clock; the only clock.
PRESETn  in  1  synchronous active-low reset, sampled on PCLK rising edge.
PSELx, PENABLE, PWRITE  in  1 each  APB control.
PADDR  in  ADDR_W  byte address.
PWDATA  in  DATA_W  write data.
PRDATA  out  DATA_W  read data; 0 when not completing a legal read.
PREADY  out  1  transfer complete.
PSLVERR  out  1  error; valid only when PREADY=1.
WR_ENA  out  1  one-cycle TX FIFO push.
WRITE_DATA_ON_TX  out  DATA_W  equals PWDATA.
TX_FULL, TX_EMPTY  in  1  TX FIFO flags.
RD_ENA  out  1  one-cycle RX FIFO pop.
READ_DATA_ON_RX  in  DATA_W  RX FIFO data.
RX_EMPTY  in  1  RX FIFO flag.
ERROR  in  1  I2C core error level.
INTERNAL_I2C_REGISTER_CONFIG  out  CFG_W  config register.
INTERNAL_I2C_REGISTER_TIMEOUT  out  TMO_W  timeout register.
IRQ  out  1  OR of (INT_STAT & INT_EN), registered.

Behaviour:
- Reset: FSM in IDLE; all registers and counters 0. IRQ=0. Combinational outputs (PREADY, PSLVERR, WR_ENA, RD_ENA, PRDATA) are 0 while PRESETn=0.
- Address map:
  - 0x00 TXDATA (W)
  - 0x04 RXDATA (R)
  - 0x08 CONFIG (RW)
  - 0x0C TIMEOUT (RW)
  - 0x10 STATUS (R) = {ERROR, RX_EMPTY, TX_FULL, TX_EMPTY} in bits [3:0]
  - 0x14 INT_EN (RW, 3 bits)
  - 0x18 INT_STAT (R/W1C, 3 bits)
- Illegal access completes in the first access cycle with PREADY=1, PSLVERR=1, no side effects and PRDATA=0. Illegal means any of: unmapped or misaligned address; PADDR[1:0]!=0; nonzero upper bits; write to RXDATA or STATUS; read of TXDATA.
- CSR access (0x08..0x18) has zero wait states: PREADY=1 in the first access cycle (PSELx & PENABLE). Writes update on that edge with the low bits of PWDATA; reads drive the zero-extended value combinationally.
- FSM states: IDLE, TX_STALL, RX_WAIT, RX_DONE.
  - IDLE, TXDATA write, TX_FULL=0: WR_ENA=1 and PREADY=1 in the same cycle; stay in IDLE.
  - IDLE, TXDATA write, TX_FULL=1: go to TX_STALL with stall_cnt=1.
  - TX_STALL: when TX_FULL falls, WR_ENA=1 and PREADY=1, then IDLE. If stall_cnt reaches STALL_MAX with TX still full, PREADY=1, PSLVERR=1, no push, then IDLE.
  - IDLE, RXDATA read, RX_EMPTY=1: PREADY=1, PSLVERR=1, no pop.
  - IDLE, RXDATA read, RX_EMPTY=0: RD_ENA=1 for that single cycle, go to RX_WAIT with lat_cnt=RD_LAT.
  - RX_WAIT: decrement lat_cnt; on the cycle lat_cnt==1, capture READ_DATA_ON_RX into rx_q, then RX_DONE.
  - RX_DONE: PREADY=1, PRDATA=rx_q, then IDLE. Total access phase is RD_LAT+2 cycles.
- RD_ENA and WR_ENA are never asserted together and never more than once per transfer.
- PSELx deasserted in a non-IDLE state is a protocol abort: return to IDLE with no push/pop pending and no register update. A pop already issued is not undone.
- Interrupts:
  - INT_STAT[0] sets on a TX_EMPTY rising edge; [1] on an RX_EMPTY falling edge; [2] on an ERROR rising edge. Edges are detected against registered previous values, which reset to TX_EMPTY=1, RX_EMPTY=1, ERROR=0.
  - A W1C write clears the selected bits; if set and clear coincide on a bit, set wins.
  - IRQ is registered: IRQ(t+1) = |(INT_STAT(t) & INT_EN(t)).
- Reset asserted mid-transfer: synchronous return to IDLE, all registers cleared, no further WR_ENA/RD_ENA.

Decomposition:
- Package apb_i2c_pkg holds:
  - the address offset localparams (TXDATA_OFF..INT_STAT_OFF);
  - the state enum typedef (IDLE, TX_STALL, RX_WAIT, RX_DONE);
  - interrupt bit index constants (INT_TXE=0, INT_RXNE=1, INT_ERR=2).
- One sub-module is natural: apb_i2c_irq, covering edge detection, INT_STAT/INT_EN and IRQ registration.

Test Plan:
- Reset then read 0x08/0x0C/0x14/0x18 -> PRDATA=0, PREADY=1 in the first access cycle, PSLVERR=0; IRQ=0.
- Write 0x08 with 0xDEAD_3FFF -> CONFIG=14'h3FFF on the next edge; read back 0x3FFF. Write 0x0C with 0x1234 -> TIMEOUT=0x1234.
- TXDATA write with TX_FULL=1 for 3 cycles then 0 -> PREADY low for 3 access cycles, then WR_ENA=PREADY=1 in one cycle, PSLVERR=0. TX_FULL held high for 20 cycles -> PSLVERR=1 after 15 stall cycles, WR_ENA never 1.
- RD_LAT=3, RX_EMPTY=0, READ_DATA_ON_RX=0xA5A5A5A5 from 3 cycles after pop -> RD_ENA=1 once, PREADY at access cycle 5, PRDATA=0xA5A5A5A5. Same read with RX_EMPTY=1 -> PREADY=1, PSLVERR=1, RD_ENA=0.
- INT_EN=0x7, pulse ERROR 0->1 -> INT_STAT=0x4 and IRQ=1 one cycle later. Write 0x18=0x4 -> INT_STAT=0, IRQ=0. W1C coinciding with a new ERROR edge -> bit stays 1.
- Write 0x10, read 0x00, access 0x1C, access 0x09 -> each gives PREADY=1, PSLVERR=1 with no register, FIFO or interrupt change.
